// File: rtl/mips_data_ram_ws_if.sv
// Data-port bus between the CPU (master) and the wait-state data RAM (slave).
interface mips_data_ram_ws_if;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        waitrequest;
  logic        err;

  modport master (
    output data_address, data_write, data_read, data_byteenable, data_writedata,
    input  data_readdata, waitrequest, err
  );

  modport slave (
    input  data_address, data_write, data_read, data_byteenable, data_writedata,
    output data_readdata, waitrequest, err
  );
endinterface

// File: rtl/mips_data_ram_ws.sv
// Data RAM with configurable wait states, per-byte write enables and a sticky error flag.
// The master holds each request until waitrequest drops in the ACK cycle.
module mips_data_ram_ws #(
  parameter int unsigned AddrBits   = 10,
  parameter int unsigned WaitCycles = 2,
  parameter logic [31:0] Base       = 32'h0000_0000
) (
  input logic               clk_i,
  input logic               rst_ni,
  mips_data_ram_ws_if.slave bus
);

  localparam int unsigned Words = 2 ** AddrBits;
  localparam int unsigned CntW  = (WaitCycles > 2) ? $clog2(WaitCycles) : 1;
  localparam logic [32:0] Span  = 33'(Words) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [AddrBits-1:0]   idx_q, idx_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  wr_q, wr_d;
  logic                  hit_q, hit_d;
  logic                  err_q, err_d;
  logic                  commit;
  logic [31:0]           mem_q [Words];

  logic                  req;
  logic [31:0]           offset;
  logic                  in_range;
  logic [AddrBits-1:0]   in_idx;

  assign req      = bus.data_read | bus.data_write;
  // Unsigned wrap makes addresses below Base land far out of range.
  assign offset   = bus.data_address - Base;
  assign in_range = {1'b0, offset} < Span;
  assign in_idx   = offset[AddrBits+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    hit_d   = hit_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          idx_d   = in_idx;
          be_d    = bus.data_byteenable;
          wdata_d = bus.data_writedata;
          wr_d    = bus.data_write;
          hit_d   = in_range;
          if ((bus.data_read && bus.data_write) || (bus.data_address[1:0] != 2'b00) ||
              !in_range) begin
            err_d = 1'b1;
          end
          if (WaitCycles == 0) begin
            state_d = StAck;
            if (!bus.data_write) begin
              rdata_d = in_range ? mem_q[in_idx] : 32'h0;
            end
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(WaitCycles - 1);
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StAck;
          if (!wr_q) begin
            rdata_d = hit_q ? mem_q[idx_q] : 32'h0;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
        // A request dropped during ACK is an abort, so nothing commits.
        commit  = req & wr_q & hit_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Words; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.data_readdata = rdata_q;
  assign bus.err           = err_q;
  assign bus.waitrequest   = req & (state_q != StAck);

endmodule

// File: tb/tb_mips_data_ram_ws.sv
// Bench for mips_data_ram_ws: one instance with two wait states, one with none.
module tb_mips_data_ram_ws;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_data_ram_ws_if bus0 ();
  mips_data_ram_ws_if bus1 ();

  mips_data_ram_ws #(.AddrBits(10), .WaitCycles(2), .Base(32'h0)) dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus0)
  );

  mips_data_ram_ws #(.AddrBits(10), .WaitCycles(0), .Base(32'h0)) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus1)
  );

  typedef struct {
    bit          sel;
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (sel) begin
      bus1.data_write = wr; bus1.data_read = rd; bus1.data_address = a;
      bus1.data_byteenable = be; bus1.data_writedata = wd;
    end else begin
      bus0.data_write = wr; bus0.data_read = rd; bus0.data_address = a;
      bus0.data_byteenable = be; bus0.data_writedata = wd;
    end
  endtask

  function automatic logic get_wreq(input bit sel);
    return sel ? bus1.waitrequest : bus0.waitrequest;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? bus1.err : bus0.err;
  endfunction

  function automatic logic [31:0] get_rd(input bit sel);
    return sel ? bus1.data_readdata : bus0.data_readdata;
  endfunction

  // Called one time unit after a rising edge; returns the same way after the closing edge.
  task automatic access(input bit sel, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err, input string name);
    int hi = 0;
    bit done = 1'b0;
    int exp_hi = sel ? 1 : 3;
    logic [31:0] e;
    drive(sel, wr, rd, a, be, wd);
    if (rd && !wr) exp_q.push_back(exp_rd);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (get_wreq(sel)) begin
        hi++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    check({name, "_ack_seen"}, 32'(done), 32'd1);
    if (done) begin
      check({name, "_wait_cycles"}, 32'(hi), 32'(exp_hi));
      check({name, "_err"}, 32'(get_err(sel)), 32'(exp_err));
      if (rd && !wr) begin
        e = exp_q.pop_front();
        check({name, "_rdata"}, get_rd(sel), e);
      end
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // sel, wr, rd, addr, be, wdata, expected rdata, expected sticky err
    vecs.push_back('{0, 1, 0, 32'h0000_0010, 4'hF, 32'h000F_FFF0, 32'h0, 0});
    vecs.push_back('{0, 0, 1, 32'h0000_0010, 4'h0, 32'h0, 32'h000F_FFF0, 0});
    vecs.push_back('{0, 1, 0, 32'h0000_0020, 4'hF, 32'hFFFF_FFFF, 32'h0, 0});
    vecs.push_back('{0, 1, 0, 32'h0000_0020, 4'b0101, 32'h1234_5678, 32'h0, 0});
    vecs.push_back('{0, 0, 1, 32'h0000_0020, 4'h0, 32'h0, 32'hFF34_FF78, 0});
    vecs.push_back('{0, 1, 0, 32'h0000_0024, 4'h0, 32'hAAAA_AAAA, 32'h0, 0});
    vecs.push_back('{0, 0, 1, 32'h0000_0024, 4'h0, 32'h0, 32'h0, 0});
    vecs.push_back('{1, 1, 0, 32'h0000_0000, 4'hF, 32'h1111_1111, 32'h0, 0});
    vecs.push_back('{1, 1, 0, 32'h0000_0004, 4'hF, 32'h2222_2222, 32'h0, 0});
    vecs.push_back('{1, 0, 1, 32'h0000_0000, 4'h0, 32'h0, 32'h1111_1111, 0});
    vecs.push_back('{1, 0, 1, 32'h0000_0004, 4'h0, 32'h0, 32'h2222_2222, 0});
    vecs.push_back('{1, 1, 1, 32'h0000_0028, 4'hF, 32'h0BAD_F00D, 32'h0, 1});
    vecs.push_back('{1, 0, 1, 32'h0000_0028, 4'h0, 32'h0, 32'h0BAD_F00D, 1});
    vecs.push_back('{0, 0, 1, 32'h0000_1000, 4'h0, 32'h0, 32'h0, 1});
    vecs.push_back('{0, 1, 0, 32'hFFFF_FFFC, 4'hF, 32'h5555_5555, 32'h0, 1});
    vecs.push_back('{0, 0, 1, 32'h0000_0FFC, 4'h0, 32'h0, 32'h0, 1});
    vecs.push_back('{0, 0, 1, 32'h0000_0013, 4'h0, 32'h0, 32'h000F_FFF0, 1});

    #12;
    check("reset_rdata0", bus0.data_readdata, 32'h0);
    check("reset_err0", 32'(bus0.err), 32'h0);
    check("reset_wreq0", 32'(bus0.waitrequest), 32'h0);
    check("reset_err1", 32'(bus1.err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Abort: drop the write during the second WAIT cycle.
    drive(1'b0, 1'b1, 1'b0, 32'h30, 4'hF, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("abort_wreq_low", 32'(bus0.waitrequest), 32'h0);
    @(posedge clk); #1;
    access(1'b0, 1'b0, 1'b1, 32'h30, 4'h0, 32'h0, 32'h0, 1'b0, "abort_read");

    foreach (vecs[i]) begin
      access(vecs[i].sel, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].wd,
             vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a write's WAIT phase.
    drive(1'b0, 1'b1, 1'b0, 32'h40, 4'hF, 32'hCAFE_F00D);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rdata", bus0.data_readdata, 32'h0);
    check("midreset_err", 32'(bus0.err), 32'h0);
    check("midreset_err1", 32'(bus1.err), 32'h0);
    check("midreset_wreq_held", 32'(bus0.waitrequest), 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 32'h0, 1'b0, "postreset_0x40");
    access(1'b0, 1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 32'h0, 1'b0, "postreset_0x10");
    access(1'b1, 1'b0, 1'b1, 32'h00, 4'h0, 32'h0, 32'h0, 1'b0, "postreset_dut1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
